// File: rtl/ais_frame_gate.sv
// Frame capture gate behind the AIS frame detector. It arms on a start-of-frame flag,
// forwards a fixed-length IQ window as one packet, holds off, and counts frames and missed flags.
module ais_frame_gate #(
  parameter int unsigned PAR_DATA_WIDTH = 16,
  parameter int unsigned PAR_FRAME_LEN  = 2048,
  parameter int unsigned PAR_HOLDOFF    = 64,
  parameter int unsigned PAR_CNT_WIDTH  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_enable,
  input  logic                        i_clr_cnt,
  input  logic                        s_axis_tvalid,
  input  logic [2*PAR_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tuser,
  output logic                        m_axis_tvalid,
  output logic [2*PAR_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic                        o_busy,
  output logic [PAR_CNT_WIDTH-1:0]    o_frame_cnt,
  output logic [PAR_CNT_WIDTH-1:0]    o_missed_cnt
);

  localparam int unsigned CNT_MAX = (PAR_FRAME_LEN > PAR_HOLDOFF) ? PAR_FRAME_LEN : PAR_HOLDOFF;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(PAR_FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((PAR_HOLDOFF == 0) ? 0 : PAR_HOLDOFF - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             fwd, fwd_first, fwd_last;
  logic             frame_inc, miss_inc;
  logic             flag;

  assign flag = s_axis_tvalid & s_axis_tuser;

  // State and sample counter register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state, forwarding decisions and statistic events
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    fwd       = 1'b0;
    fwd_first = 1'b0;
    fwd_last  = 1'b0;
    frame_inc = 1'b0;
    miss_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (flag) begin
          if (i_enable) begin
            fwd       = 1'b1;
            fwd_first = 1'b1;
            frame_inc = 1'b1;
            if (PAR_FRAME_LEN == 1) begin
              fwd_last = 1'b1;
              cnt_nx   = '0;
              state_nx = (PAR_HOLDOFF == 0) ? IDLE : HOLDOFF;
            end else begin
              cnt_nx   = CNT_W'(1);
              state_nx = CAPTURE;
            end
          end else begin
            miss_inc = 1'b1;
          end
        end
      end
      CAPTURE: begin
        if (s_axis_tvalid) begin
          fwd      = 1'b1;
          miss_inc = s_axis_tuser;
          if (cnt == FRAME_LAST) begin
            fwd_last = 1'b1;
            cnt_nx   = '0;
            state_nx = (PAR_HOLDOFF == 0) ? IDLE : HOLDOFF;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      HOLDOFF: begin
        if (s_axis_tvalid) begin
          miss_inc = s_axis_tuser;
          if (cnt == HOLD_LAST) begin
            cnt_nx   = '0;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Registered output stream and busy flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      m_axis_tvalid <= fwd;
      m_axis_tuser  <= fwd_first;
      m_axis_tlast  <= fwd_last;
      o_busy        <= (state_nx != IDLE);
      if (fwd) begin
        m_axis_tdata <= s_axis_tdata;
      end
    end
  end

  // Saturating statistics; a coincident clear wins over the increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_cnt  <= '0;
      o_missed_cnt <= '0;
    end else if (i_clr_cnt) begin
      o_frame_cnt  <= '0;
      o_missed_cnt <= '0;
    end else begin
      if (frame_inc && (o_frame_cnt != '1)) begin
        o_frame_cnt <= o_frame_cnt + PAR_CNT_WIDTH'(1);
      end
      if (miss_inc && (o_missed_cnt != '1)) begin
        o_missed_cnt <= o_missed_cnt + PAR_CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_ais_frame_gate.sv
// Directed bench for ais_frame_gate: frame length 4, hold-off 2 and 2-bit counters,
// with every expected value written out by hand.
module tb_ais_frame_gate;

  localparam int unsigned DW = 16;
  localparam int unsigned FL = 4;
  localparam int unsigned HO = 2;
  localparam int unsigned CW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b1;
  logic            clr_cnt = 1'b0;
  logic            s_tvalid = 1'b0;
  logic [2*DW-1:0] s_tdata = '0;
  logic            s_tuser = 1'b0;
  logic            m_tvalid;
  logic [2*DW-1:0] m_tdata;
  logic            m_tuser;
  logic            m_tlast;
  logic            busy;
  logic [CW-1:0]   frame_cnt;
  logic [CW-1:0]   missed_cnt;

  int vectors = 0;
  int miscompares = 0;

  ais_frame_gate #(
    .PAR_DATA_WIDTH(DW),
    .PAR_FRAME_LEN (FL),
    .PAR_HOLDOFF   (HO),
    .PAR_CNT_WIDTH (CW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (enable),
    .i_clr_cnt    (clr_cnt),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tdata (s_tdata),
    .s_axis_tuser (s_tuser),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tdata (m_tdata),
    .m_axis_tuser (m_tuser),
    .m_axis_tlast (m_tlast),
    .o_busy       (busy),
    .o_frame_cnt  (frame_cnt),
    .o_missed_cnt (missed_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dat(input int k);
    return 32'h3000_1000 + 32'(k) * 32'h0001_0001;
  endfunction

  // Present one clock of input; returns #1 after the consuming edge
  task automatic step(input logic v, input logic [31:0] d, input logic u);
    @(negedge clk);
    s_tvalid = v;
    s_tdata  = d;
    s_tuser  = u;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] d,
                            input logic u, input logic l);
    check({tag, ".tvalid"}, 64'(m_tvalid), 64'(v));
    if (v) check({tag, ".tdata"}, 64'(m_tdata), 64'(d));
    check({tag, ".tuser"}, 64'(m_tuser), 64'(u));
    check({tag, ".tlast"}, 64'(m_tlast), 64'(l));
  endtask

  task automatic clear_counters();
    clr_cnt = 1'b1;
    step(1'b0, '0, 1'b0);
    check("clr.frame", 64'(frame_cnt), 64'd0);
    check("clr.missed", 64'(missed_cnt), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    expect_out("reset", 1'b0, '0, 1'b0, 1'b0);
    check("reset.tdata", 64'(m_tdata), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.frame", 64'(frame_cnt), 64'd0);
    check("reset.missed", 64'(missed_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame: flag on D1, frame D1..D4, hold-off D5..D6
    clear_counters();
    for (int k = 0; k <= 9; k++) begin
      step(1'b1, dat(k), k == 1);
      expect_out($sformatf("basic.D%0d", k), (k >= 1 && k <= 4), dat(k), k == 1, k == 4);
      check($sformatf("basic.busy%0d", k), 64'(busy), 64'(k >= 1 && k <= 5));
    end
    check("basic.frame", 64'(frame_cnt), 64'd1);
    check("basic.missed", 64'(missed_cnt), 64'd0);

    // Flags during frame (D3) and hold-off (D6); D7 starts a new frame
    clear_counters();
    for (int k = 0; k <= 12; k++) begin
      step(1'b1, dat(k), (k == 1 || k == 3 || k == 6 || k == 7));
      expect_out($sformatf("flags.D%0d", k),
                 ((k >= 1 && k <= 4) || (k >= 7 && k <= 10)), dat(k),
                 (k == 1 || k == 7), (k == 4 || k == 10));
      check($sformatf("flags.busy%0d", k), 64'(busy),
            64'((k >= 1 && k <= 5) || (k >= 7 && k <= 11)));
      if (k == 6) begin
        check("flags.missed6", 64'(missed_cnt), 64'd2);
        check("flags.frame6", 64'(frame_cnt), 64'd1);
      end
    end
    check("flags.frame", 64'(frame_cnt), 64'd2);
    check("flags.missed", 64'(missed_cnt), 64'd2);

    // Flag while disabled is counted as missed
    clear_counters();
    enable = 1'b0;
    step(1'b1, dat(20), 1'b1);
    expect_out("dis.flag", 1'b0, '0, 1'b0, 1'b0);
    check("dis.busy", 64'(busy), 64'd0);
    check("dis.missed", 64'(missed_cnt), 64'd1);

    // Enable dropped after arming: full frame still emitted
    enable = 1'b1;
    step(1'b1, dat(21), 1'b1);
    expect_out("en.D21", 1'b1, dat(21), 1'b1, 1'b0);
    enable = 1'b0;
    for (int k = 22; k <= 26; k++) begin
      step(1'b1, dat(k), 1'b0);
      expect_out($sformatf("en.D%0d", k), k <= 24, dat(k), 1'b0, k == 24);
    end
    check("en.busy", 64'(busy), 64'd0);

    // tvalid gaps inside frame and hold-off
    enable = 1'b1;
    step(1'b1, dat(30), 1'b1);
    expect_out("gap.D30", 1'b1, dat(30), 1'b1, 1'b0);
    for (int j = 1; j <= 3; j++) begin
      for (int g = 0; g < 2 * j - 1; g++) begin
        step(1'b0, '0, 1'b0);
        expect_out($sformatf("gap.idle%0d_%0d", j, g), 1'b0, '0, 1'b0, 1'b0);
      end
      step(1'b1, dat(30 + j), 1'b0);
      expect_out($sformatf("gap.D%0d", 30 + j), 1'b1, dat(30 + j), 1'b0, j == 3);
    end
    step(1'b1, dat(34), 1'b0);
    for (int g = 0; g < 5; g++) step(1'b0, '0, 1'b0);
    check("gap.busy_hold", 64'(busy), 64'd1);
    step(1'b1, dat(35), 1'b0);
    expect_out("gap.D35", 1'b0, '0, 1'b0, 1'b0);
    check("gap.busy_end", 64'(busy), 64'd0);
    check("gap.frame", 64'(frame_cnt), 64'd2);
    check("gap.missed", 64'(missed_cnt), 64'd1);

    // Frame counter saturates at 3 with a 2-bit width
    clear_counters();
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 6; k++) step(1'b1, dat(40 + k), k == 0);
      check($sformatf("sat.tlast_seen%0d", f), 64'(busy), 64'd0);
    end
    check("sat.frame", 64'(frame_cnt), 64'd3);

    // Clear coincident with an arming flag: clear wins, frame still forwarded
    clr_cnt = 1'b1;
    step(1'b1, dat(50), 1'b1);
    expect_out("clr.D50", 1'b1, dat(50), 1'b1, 1'b0);
    check("clrarm.frame", 64'(frame_cnt), 64'd0);
    for (int k = 51; k <= 55; k++) begin
      step(1'b1, dat(k), 1'b0);
      expect_out($sformatf("clr.D%0d", k), k <= 53, dat(k), 1'b0, k == 53);
    end
    check("clrarm.frame_end", 64'(frame_cnt), 64'd0);

    // Asynchronous reset mid-frame
    step(1'b1, dat(60), 1'b1);
    expect_out("rst.D60", 1'b1, dat(60), 1'b1, 1'b0);
    step(1'b1, dat(61), 1'b0);
    expect_out("rst.D61", 1'b1, dat(61), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("rst.async", 1'b0, '0, 1'b0, 1'b0);
    check("rst.tdata", 64'(m_tdata), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.frame", 64'(frame_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, dat(62), 1'b0);
    expect_out("rst.D62", 1'b0, '0, 1'b0, 1'b0);
    check("rst.busy62", 64'(busy), 64'd0);
    step(1'b1, dat(63), 1'b1);
    expect_out("rst.D63", 1'b1, dat(63), 1'b1, 1'b0);
    check("rst.frame63", 64'(frame_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ais_frame_gate.md
# ais_frame_gate

Frame capture controller placed directly after the AIS frame detector. It consumes the detector's aligned IQ stream and its start-of-frame flag (tuser), arms on a flag and forwards a fixed-length window of samples as one framed packet. It then enforces a hold-off before re-arming and keeps frame/missed-flag statistics for the control processor.

## Interface
- PAR_DATA_WIDTH, 16, width of I and of Q; tdata = {Q, I}.
- PAR_FRAME_LEN, 2048, samples forwarded per frame, counting the flagged sample; must be >= 1.
- PAR_HOLDOFF, 64, valid samples discarded after a frame before re-arming; 0 means re-arm immediately.
- PAR_CNT_WIDTH, 16, width of the statistics counters.

- i_clk, input, 1, clock.
- i_rst_n, input, 1, reset; asynchronous, active-low.
- i_enable, input, 1, permits arming from IDLE.
- i_clr_cnt, input, 1, synchronous clear of both statistics counters.
- s_axis_tvalid, input, 1, sample valid; no backpressure, so there is no tready.
- s_axis_tdata, input, 2*PAR_DATA_WIDTH, IQ sample.
- s_axis_tuser, input, 1, start-of-frame flag; meaningful only with tvalid.
- m_axis_tvalid, output, 1, forwarded sample valid.
- m_axis_tdata, output, 2*PAR_DATA_WIDTH, forwarded IQ sample.
- m_axis_tuser, output, 1, first sample of the frame.
- m_axis_tlast, output, 1, last sample of the frame.
- o_busy, output, 1, state is not IDLE.
- o_frame_cnt, output, PAR_CNT_WIDTH, frames started; saturates at all-ones.
- o_missed_cnt, output, PAR_CNT_WIDTH, flags ignored because they arrived while not IDLE, or while IDLE with i_enable low; saturates at all-ones.

## Operation
- FSM states: IDLE, CAPTURE, HOLDOFF. A single sample counter, cnt, is used, wide enough for max(PAR_FRAME_LEN, PAR_HOLDOFF). The counter advances only on s_axis_tvalid.
- IDLE:
  - On a valid sample with tuser=1 and i_enable=1: forward the sample with m_axis_tuser=1, set cnt=1, increment o_frame_cnt.
  - Next state: CAPTURE. If PAR_FRAME_LEN=1, tlast is also 1 and the next state follows the end-of-frame rule.
  - Flag with i_enable=0: increment o_missed_cnt, stay IDLE.
  - Samples are not forwarded in IDLE unless they arm the gate.
- CAPTURE:
  - Forward every valid sample and increment cnt.
  - The sample on which cnt reaches PAR_FRAME_LEN carries m_axis_tlast=1.
  - End of frame: go to HOLDOFF with cnt=0, or to IDLE if PAR_HOLDOFF=0.
- HOLDOFF:
  - Discard valid samples and increment cnt.
  - When the PAR_HOLDOFF-th sample is consumed, go to IDLE. That sample cannot re-arm the gate.
- Missed flags:
  - Any tuser=1 on a valid sample in CAPTURE or HOLDOFF increments o_missed_cnt.
  - This includes the flag on the tlast sample and on the final hold-off sample.
  - A flag on a forwarded non-first sample is forwarded with m_axis_tuser=0.
- i_enable affects arming only. Deasserting it mid-frame or mid-hold-off does not truncate; the frame completes normally.
- Counters:
  - Increments saturate at 2^PAR_CNT_WIDTH-1.
  - If i_clr_cnt coincides with an increment, the clear wins and the counter becomes 0; that event is not counted.

## Timing
- All outputs are registered. Forwarded outputs appear 1 clock after the accepted input sample.
- m_axis_tvalid is high for exactly one clock per forwarded sample.
- m_axis_tdata, m_axis_tuser and m_axis_tlast are valid when m_axis_tvalid=1; tuser and tlast are 0 otherwise.
- State transitions take effect on the clock edge that consumes the triggering sample. The next valid sample sees the new state.
- o_busy rises 1 clock after the arming sample and falls 1 clock after the sample that ends hold-off (or after the tlast sample when PAR_HOLDOFF=0).
- Counter updates are visible 1 clock after the event or after i_clr_cnt.
- Reset (asynchronous): state=IDLE, cnt=0, all outputs 0, including both counters. Reset mid-frame aborts without a tlast; the next frame requires a fresh flag.
- Gaps in tvalid of any length inside CAPTURE or HOLDOFF stretch the frame; no timeout applies.

## Test plan
- Use PAR_FRAME_LEN=4, PAR_HOLDOFF=2, i_enable=1 throughout unless stated.
- Basic frame: samples D0..D9 with tuser on D1.
  - Output D1(tuser=1), D2, D3, D4(tlast=1), each 1 clock after its input.
  - D5 and D6 are dropped; o_frame_cnt=1, o_busy low after D6.
- Flags during frame and hold-off: tuser on D1, D3 and D6.
  - Frame D1..D4 as above; D3 is forwarded with tuser=0.
  - o_missed_cnt=2, o_frame_cnt=1.
  - A flag on D7 starts a new frame D7..D10.
- Enable gating and stalls:
  - Flag with i_enable=0: no output, o_missed_cnt=1.
  - i_enable dropped after arming: the full 4-sample frame is still emitted.
  - tvalid gaps of 0..5 clocks inside the frame: same 4 outputs, tlast on the 4th.
- Counter boundaries: PAR_CNT_WIDTH=2.
  - Five frames give o_frame_cnt=3 (saturated).
  - i_clr_cnt coincident with an arming flag gives o_frame_cnt=0, and the frame is still forwarded.
- Reset mid-frame: assert i_rst_n=0 asynchronously after D2 is forwarded.
  - Outputs go to 0 immediately, with no tlast.
  - After release, D3 carrying no flag produces no output.
